// File: rtl/wb_uart_bridge.sv
// Registered Wishbone slave-to-master bridge in front of the UART channel group.
// It keeps one transaction in flight and returns an error pulse if the downstream ack never arrives.
module wb_uart_bridge #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CH_LO   = 20
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [31:0] s_adr_i,
    input  logic [31:0] s_dat_i,
    input  logic [3:0]  s_sel_i,
    input  logic        s_we_i,
    input  logic        s_stb_i,
    input  logic        s_cyc_i,
    output logic [31:0] s_dat_o,
    output logic        s_ack_o,
    output logic        s_err_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    output logic [3:0]  m_sel_o,
    output logic        m_we_o,
    output logic        m_stb_o,
    output logic        m_cyc_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    output logic [3:0]  last_ch_o,
    output logic [7:0]  timeout_cnt_o
);

    localparam int unsigned WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t            state_q, state_d;
    logic [31:0]       m_adr_q, m_adr_d;
    logic [31:0]       m_dat_q, m_dat_d;
    logic [3:0]        m_sel_q, m_sel_d;
    logic              m_we_q, m_we_d;
    logic [31:0]       s_dat_q, s_dat_d;
    logic              s_ack_q, s_ack_d;
    logic              s_err_q, s_err_d;
    logic [3:0]        last_ch_q, last_ch_d;
    logic [7:0]        tmo_cnt_q, tmo_cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    always_comb begin
        state_d   = state_q;
        m_adr_d   = m_adr_q;
        m_dat_d   = m_dat_q;
        m_sel_d   = m_sel_q;
        m_we_d    = m_we_q;
        s_dat_d   = s_dat_q;
        s_ack_d   = 1'b0;
        s_err_d   = 1'b0;
        last_ch_d = last_ch_q;
        tmo_cnt_d = tmo_cnt_q;
        wait_d    = wait_q;
        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (s_cyc_i && s_stb_i && !s_ack_q && !s_err_q) begin
                    m_adr_d = s_adr_i;
                    m_dat_d = s_dat_i;
                    m_sel_d = s_sel_i;
                    m_we_d  = s_we_i;
                    state_d = REQ;
                end
            end
            REQ: begin
                // An ack arriving on the final wait cycle wins over the timeout.
                if (m_ack_i) begin
                    if (!m_we_q) begin
                        s_dat_d = m_dat_i;
                    end
                    s_ack_d   = 1'b1;
                    last_ch_d = m_adr_q[CH_LO +: 4];
                    state_d   = RESP;
                end else if (wait_q == WAIT_LAST) begin
                    s_err_d   = 1'b1;
                    last_ch_d = m_adr_q[CH_LO +: 4];
                    if (tmo_cnt_q != 8'hFF) begin
                        tmo_cnt_d = tmo_cnt_q + 8'd1;
                    end
                    state_d = RESP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RESP: begin
                wait_d  = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= IDLE;
            m_adr_q   <= '0;
            m_dat_q   <= '0;
            m_sel_q   <= '0;
            m_we_q    <= 1'b0;
            s_dat_q   <= '0;
            s_ack_q   <= 1'b0;
            s_err_q   <= 1'b0;
            last_ch_q <= '0;
            tmo_cnt_q <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            m_adr_q   <= m_adr_d;
            m_dat_q   <= m_dat_d;
            m_sel_q   <= m_sel_d;
            m_we_q    <= m_we_d;
            s_dat_q   <= s_dat_d;
            s_ack_q   <= s_ack_d;
            s_err_q   <= s_err_d;
            last_ch_q <= last_ch_d;
            tmo_cnt_q <= tmo_cnt_d;
            wait_q    <= wait_d;
        end
    end

    // The downstream strobe is simply "in REQ", so it drops on the edge that leaves REQ.
    assign m_cyc_o       = (state_q == REQ);
    assign m_stb_o       = (state_q == REQ);
    assign m_adr_o       = m_adr_q;
    assign m_dat_o       = m_dat_q;
    assign m_sel_o       = m_sel_q;
    assign m_we_o        = m_we_q;
    assign s_dat_o       = s_dat_q;
    assign s_ack_o       = s_ack_q;
    assign s_err_o       = s_err_q;
    assign last_ch_o     = last_ch_q;
    assign timeout_cnt_o = tmo_cnt_q;

endmodule

// File: doc/wb_uart_bridge.md
WB_UART_BRIDGE -- requirements
Module: wb_uart_bridge

Purpose: registered Wishbone slave-to-master bridge placed directly upstream of the 16-channel UART group; one transaction in flight; bus timeout with error response.

Interface
REQ-001 Parameters SHALL be: TIMEOUT, 255, cycles to wait for downstream ack before error; CH_LO, 20, LSB of the 4-bit channel field in the address.
REQ-002 wb_clk_i  in  1  single clock; all logic on its rising edge.
REQ-003 wb_rst_n_i  in  1  reset; synchronous, active-low.
REQ-004 s_adr_i  in  32  upstream address.
REQ-005 s_dat_i  in  32  upstream write data.
REQ-006 s_sel_i  in  4  upstream byte selects.
REQ-007 s_we_i, s_stb_i, s_cyc_i  in  1 each  upstream Wishbone controls.
REQ-008 s_dat_o  out  32  read data returned upstream.
REQ-009 s_ack_o  out  1  one-cycle normal completion.
REQ-010 s_err_o  out  1  one-cycle error completion (timeout).
REQ-011 m_adr_o, m_dat_o  out  32 each  downstream address and write data.
REQ-012 m_sel_o  out  4  downstream byte selects.
REQ-013 m_we_o, m_stb_o, m_cyc_o  out  1 each  downstream controls.
REQ-014 m_dat_i  in  32  downstream read data.
REQ-015 m_ack_i  in  1  downstream ack.
REQ-016 last_ch_o  out  4  channel field of the last completed transaction.
REQ-017 timeout_cnt_o  out  8  saturating count of timed-out transactions.

Function
REQ-018 FSM SHALL have states IDLE, REQ, RESP.
REQ-019 IDLE: when s_cyc_i & s_stb_i & !s_ack_o & !s_err_o, capture s_adr_i, s_dat_i, s_sel_i, s_we_i into m_* registers, assert m_cyc_o/m_stb_o next cycle, go to REQ.
REQ-020 REQ: m_cyc_o, m_stb_o and all m_* payload SHALL stay constant; wait counter increments each cycle from 0.
REQ-021 REQ with m_ack_i=1: latch m_dat_i into s_dat_o (reads only; writes leave s_dat_o unchanged), deassert m_cyc_o/m_stb_o, go to RESP; s_ack_o=1 for exactly the RESP cycle.
REQ-022 REQ with counter == TIMEOUT and m_ack_i=0: deassert m_cyc_o/m_stb_o, go to RESP with s_err_o=1 for exactly that cycle, s_dat_o unchanged, timeout_cnt_o += 1 saturating at 255.
REQ-023 m_ack_i and timeout in the same cycle SHALL resolve as ack (no error, no count).
REQ-024 RESP SHALL always return to IDLE next cycle; s_ack_o and s_err_o SHALL never be high together.
REQ-025 Latency: request sampled cycle N -> m_stb_o high N+1; ack sampled cycle M -> s_ack_o high M+1; minimum 3 cycles request to ack.
REQ-026 m_ack_i while not in REQ SHALL be ignored.
REQ-027 Upstream dropping s_cyc_i during REQ SHALL NOT abort the downstream cycle; the completion pulse is still issued.
REQ-028 last_ch_o SHALL update to m_adr_o[CH_LO+3:CH_LO] on entering RESP (ack or error).
REQ-029 A new request SHALL NOT be accepted in the RESP cycle; back-to-back requests restart from IDLE.

Reset
REQ-030 wb_rst_n_i=0 at a clock edge SHALL force IDLE; m_cyc_o, m_stb_o, m_we_o, s_ack_o, s_err_o = 0; m_adr_o, m_dat_o, s_dat_o = 0; m_sel_o = 0; last_ch_o = 0; timeout_cnt_o = 0; wait counter = 0.
REQ-031 Reset in REQ SHALL drop m_cyc_o/m_stb_o next edge with no completion pulse upstream.

Verification
REQ-032 Read: s_adr_i=0x0030_0014, stb/cyc=1, m_ack_i 2 cycles after m_stb_o with m_dat_i=0x0000_00A5 -> s_ack_o one cycle, s_dat_o=0xA5, last_ch_o=3.
REQ-033 Write: s_adr_i=0x00F0_0000, s_dat_i=0x55, s_sel_i=0x1 -> m_adr_o/m_dat_o/m_sel_o match and are stable until m_ack_i; s_ack_o pulses; s_dat_o unchanged.
REQ-034 Timeout: no m_ack_i -> m_stb_o drops after TIMEOUT+1 cycles, s_err_o pulses once, timeout_cnt_o=1; repeat 300 times -> timeout_cnt_o=255.
REQ-035 Race: m_ack_i asserted on the cycle counter==TIMEOUT -> s_ack_o=1, s_err_o=0, timeout_cnt_o unchanged.
REQ-036 Reset mid-REQ: wb_rst_n_i low for 1 cycle during REQ -> all outputs at reset values next edge, no s_ack_o/s_err_o pulse, next request completes normally.
